// File: rtl/multi_cache.sv
// multi_cache: N-way set-associative L1 data cache, 16 sets x 16-byte lines, LRU or LFSR victim, hit/miss/access counters.
// Latency: 1 cycle; response, miss flag, counters and cache state all update on the accepting edge.
// Backpressure: none; one access accepted every cycle with ivalid=1 and rst=0, no stall or ready.
module multi_cache #(
  parameter int WAY_COUNT              = 4,
  parameter int USE_RANDOM_REPLACEMENT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ivalid,
  input  logic        iRW,
  input  logic [10:0] iaddress,
  input  logic [7:0]  iRAM32 [0:31],
  input  logic [7:0]  iwrite_data,
  output logic        L1miss,
  output logic        ovalid,
  output logic [7:0]  oread_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] total_accesses
);
  // Way-index / age width; a direct-mapped cache still carries a 1-bit index.
  localparam int WB = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;

  logic             r_valid [0:15][0:WAY_COUNT-1];
  logic [2:0]       r_tag   [0:15][0:WAY_COUNT-1];
  logic [WB-1:0]    r_age   [0:15][0:WAY_COUNT-1];
  logic [15:0][7:0] r_data  [0:15][0:WAY_COUNT-1];
  logic [15:0]      r_lfsr;
  logic             r_ovalid;
  logic             r_miss;
  logic [7:0]       r_rdata;
  logic [31:0]      r_hits;
  logic [31:0]      r_misses;
  logic [31:0]      r_total;

  logic [3:0]       w_set;
  logic [2:0]       w_tag;
  logic [3:0]       w_off;
  logic             w_hit;
  logic             w_inv_found;
  logic [WB-1:0]    w_hit_way;
  logic [WB-1:0]    w_inv_way;
  logic [WB-1:0]    w_lru_way;
  logic [WB-1:0]    w_max_age;
  logic [WB-1:0]    w_rand_way;
  logic [WB-1:0]    w_victim;
  logic [WB-1:0]    w_way;
  logic [WB-1:0]    w_old_age;
  logic [15:0][7:0] w_fill;
  logic [15:0][7:0] w_line;
  logic [15:0][7:0] w_new_line;
  logic [7:0]       w_rdata;

  assign w_set      = iaddress[7:4];
  assign w_tag      = iaddress[10:8];
  assign w_off      = iaddress[3:0];
  assign w_rand_way = (WAY_COUNT == 1) ? '0 : r_lfsr[WB-1:0];
  assign w_old_age  = r_age[w_set][w_way];

  assign ovalid         = r_ovalid;
  assign L1miss         = r_miss;
  assign oread_data     = r_rdata;
  assign hit_count      = r_hits;
  assign miss_count     = r_misses;
  assign total_accesses = r_total;

  // Tag match, lowest invalid way and oldest (LRU) way in the addressed set.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    w_max_age   = '0;
    // Scan downwards so the last invalid way seen is the lowest-numbered one.
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WB'(w);
      end
    end
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WB'(w);
      end
      // Ages in a set are a permutation, so the maximum is unique.
      if (r_age[w_set][w] >= w_max_age) begin
        w_max_age = r_age[w_set][w];
        w_lru_way = WB'(w);
      end
    end
  end

  // Victim selection: free way first, then the configured policy.
  always_comb begin
    if (w_inv_found) begin
      w_victim = w_inv_way;
    end else if (USE_RANDOM_REPLACEMENT != 0) begin
      w_victim = w_rand_way;
    end else begin
      w_victim = w_lru_way;
    end
    w_way = w_hit ? w_hit_way : w_victim;
  end

  // Build the line as it will look after this access and pick the response byte.
  always_comb begin
    w_fill = '0;
    // The fill window half is chosen by the set-index LSB.
    for (int k = 0; k < 16; k++) begin
      w_fill[k] = iRAM32[{iaddress[4], k[3:0]}];
    end
    w_line     = w_hit ? r_data[w_set][w_hit_way] : w_fill;
    w_new_line = w_line;
    if (iRW) begin
      w_new_line[w_off] = iwrite_data;
    end
    w_rdata = iRW ? iwrite_data : w_line[w_off];
  end

  // Control state: valid/tag/age, LFSR, response registers and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 16; s++) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
          r_valid[s][w] <= 1'b0;
          r_age[s][w]   <= WB'(w);
        end
      end
      r_lfsr   <= 16'hACE1;
      r_ovalid <= 1'b0;
      r_miss   <= 1'b0;
      r_rdata  <= 8'h00;
      r_hits   <= 32'd0;
      r_misses <= 32'd0;
      r_total  <= 32'd0;
    end else begin
      r_lfsr   <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_ovalid <= ivalid;
      r_miss   <= ivalid && !w_hit;
      if (ivalid) begin
        r_rdata <= w_rdata;
        r_total <= r_total + 32'd1;
        if (w_hit) begin
          r_hits <= r_hits + 32'd1;
        end else begin
          r_misses <= r_misses + 32'd1;
        end
        r_valid[w_set][w_way] <= 1'b1;
        r_tag[w_set][w_way]   <= w_tag;
        for (int w = 0; w < WAY_COUNT; w++) begin
          if (WB'(w) == w_way) begin
            r_age[w_set][w] <= '0;
          end else if (r_age[w_set][w] < w_old_age) begin
            r_age[w_set][w] <= r_age[w_set][w] + WB'(1);
          end
        end
      end
    end
  end

  // Line data needs no reset: it is only read through a valid tag match.
  always_ff @(posedge clk) begin
    if (!rst && ivalid) begin
      r_data[w_set][w_way] <= w_new_line;
    end
  end
endmodule

// File: tb/tb_multi_cache.sv
// tb_multi_cache: scoreboard bench for multi_cache in 4-way LRU, 4-way random and direct-mapped builds.
// Latency: expects each response one cycle after the access is driven.
// Backpressure: none; the bench drives one access per cycle at most.
module tb_multi_cache;
  typedef struct packed {
    logic       miss;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic        iRW = 1'b0;
  logic [10:0] iaddress = '0;
  logic [7:0]  iwrite_data = '0;
  logic [7:0]  ram [0:31];

  logic        l_miss, l_vld, r_miss, r_vld, d_miss, d_vld;
  logic [7:0]  l_dat, r_dat, d_dat;
  logic [31:0] l_hit, l_mis, l_tot, r_hit, r_mis, r_tot, d_hit, d_mis, d_tot;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;

  multi_cache #(.WAY_COUNT(4), .USE_RANDOM_REPLACEMENT(0)) u_lru (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iRW(iRW), .iaddress(iaddress), .iRAM32(ram),
    .iwrite_data(iwrite_data), .L1miss(l_miss), .ovalid(l_vld), .oread_data(l_dat),
    .hit_count(l_hit), .miss_count(l_mis), .total_accesses(l_tot));

  multi_cache #(.WAY_COUNT(4), .USE_RANDOM_REPLACEMENT(1)) u_rnd (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iRW(iRW), .iaddress(iaddress), .iRAM32(ram),
    .iwrite_data(iwrite_data), .L1miss(r_miss), .ovalid(r_vld), .oread_data(r_dat),
    .hit_count(r_hit), .miss_count(r_mis), .total_accesses(r_tot));

  multi_cache #(.WAY_COUNT(1), .USE_RANDOM_REPLACEMENT(0)) u_dm (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iRW(iRW), .iaddress(iaddress), .iRAM32(ram),
    .iwrite_data(iwrite_data), .L1miss(d_miss), .ovalid(d_vld), .oread_data(d_dat),
    .hit_count(d_hit), .miss_count(d_mis), .total_accesses(d_tot));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Drive one cycle of stimulus and return #1 after the capturing edge.
  task automatic step(input logic v, input logic rw, input logic [10:0] a, input logic [7:0] wd, input logic r);
    @(negedge clk);
    rst = r; ivalid = v; iRW = rw; iaddress = a; iwrite_data = wd;
    @(posedge clk);
    #1;
    ivalid = 1'b0; rst = 1'b0;
  endtask

  task automatic ram_pattern(input logic [7:0] base);
    for (int i = 0; i < 32; i++) ram[i] = 8'(base + 8'(i));
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 11'h150, 8'h00, 1'b1);
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
    n_cmp++; if (l_vld !== 1'b0 || l_miss !== 1'b0 || l_dat !== 8'h00) begin n_fail++;
      $display("FAIL reset_outputs: got vld=%b miss=%b data=%h, need 0 0 00", l_vld, l_miss, l_dat); end
    n_cmp++; if (l_hit !== 0 || l_mis !== 0 || l_tot !== 0) begin n_fail++;
      $display("FAIL reset_counters: got h=%0d m=%0d t=%0d, need 0 0 0", l_hit, l_mis, l_tot); end
    n_cmp++; if (r_tot !== 0 || d_tot !== 0 || r_vld !== 1'b0 || d_vld !== 1'b0) begin n_fail++;
      $display("FAIL reset_other_builds: got rt=%0d dt=%0d rv=%b dv=%b, need 0 0 0 0", r_tot, d_tot, r_vld, d_vld); end
  endtask

  task automatic test_cold_read;
    sb.push_back('{miss: 1'b1, data: 8'hF0});
    step(1'b1, 1'b0, 11'h150, 8'h00, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
      $display("FAIL cold_read: got vld=%b miss=%b data=%h, need 1 %b %h", l_vld, l_miss, l_dat, e.miss, e.data); end
    n_cmp++; if (l_mis !== 1 || l_hit !== 0 || l_tot !== 1) begin n_fail++;
      $display("FAIL cold_counters: got h=%0d m=%0d t=%0d, need 0 1 1", l_hit, l_mis, l_tot); end
    sb.push_back('{miss: 1'b0, data: 8'hF0});
    step(1'b1, 1'b0, 11'h150, 8'h00, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
      $display("FAIL repeat_read: got vld=%b miss=%b data=%h, need 1 %b %h", l_vld, l_miss, l_dat, e.miss, e.data); end
    n_cmp++; if (l_hit !== 1 || l_mis !== 1 || l_tot !== 2) begin n_fail++;
      $display("FAIL repeat_counters: got h=%0d m=%0d t=%0d, need 1 1 2", l_hit, l_mis, l_tot); end
  endtask

  task automatic test_idle;
    step(1'b0, 1'b1, 11'h7FF, 8'h55, 1'b0);
    n_cmp++; if (l_vld !== 1'b0 || l_miss !== 1'b0 || l_dat !== 8'hF0) begin n_fail++;
      $display("FAIL idle_outputs: got vld=%b miss=%b data=%h, need 0 0 f0", l_vld, l_miss, l_dat); end
    n_cmp++; if (l_hit !== 1 || l_mis !== 1 || l_tot !== 2) begin n_fail++;
      $display("FAIL idle_counters: got h=%0d m=%0d t=%0d, need 1 1 2", l_hit, l_mis, l_tot); end
  endtask

  task automatic test_write_alloc;
    logic [10:0] addr [0:2];
    logic        rw [0:2];
    addr[0] = 11'h153; addr[1] = 11'h153; addr[2] = 11'h154;
    rw[0] = 1'b1; rw[1] = 1'b0; rw[2] = 1'b0;
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    sb.push_back('{miss: 1'b1, data: 8'h3C});
    sb.push_back('{miss: 1'b0, data: 8'h3C});
    sb.push_back('{miss: 1'b0, data: 8'hF4});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rw[i], addr[i], 8'h3C, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
        $display("FAIL write_alloc[%0d]: got vld=%b miss=%b data=%h, need 1 %b %h", i, l_vld, l_miss, l_dat, e.miss, e.data); end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] addr [0:4];
    logic        rw [0:4];
    logic [7:0]  wd [0:4];
    addr[0] = 11'h3A5; rw[0] = 1'b1; wd[0] = 8'h77; sb.push_back('{miss: 1'b1, data: 8'h77});
    addr[1] = 11'h3A5; rw[1] = 1'b0; wd[1] = 8'h00; sb.push_back('{miss: 1'b0, data: 8'h77});
    addr[2] = 11'h3A5; rw[2] = 1'b1; wd[2] = 8'h88; sb.push_back('{miss: 1'b0, data: 8'h88});
    addr[3] = 11'h3A5; rw[3] = 1'b0; wd[3] = 8'h00; sb.push_back('{miss: 1'b0, data: 8'h88});
    addr[4] = 11'h3A6; rw[4] = 1'b0; wd[4] = 8'h00; sb.push_back('{miss: 1'b0, data: 8'hE6});
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rw[i], addr[i], wd[i], 1'b0);
      e = sb.pop_front();
      n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
        $display("FAIL back_to_back[%0d]: got vld=%b miss=%b data=%h, need 1 %b %h", i, l_vld, l_miss, l_dat, e.miss, e.data); end
    end
  endtask

  task automatic test_lru_thrash;
    logic [2:0] tg;
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tg = 3'((i % 5) + 1);
      sb.push_back('{miss: 1'b1, data: 8'hF0});
      step(1'b1, 1'b0, {tg, 8'h50}, 8'h00, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
        $display("FAIL lru_thrash[%0d]: got vld=%b miss=%b data=%h, need 1 %b %h", i, l_vld, l_miss, l_dat, e.miss, e.data); end
    end
    n_cmp++; if (l_tot !== 10 || l_mis !== 10 || l_hit !== 0) begin n_fail++;
      $display("FAIL lru_thrash_counters: got h=%0d m=%0d t=%0d, need 0 10 10", l_hit, l_mis, l_tot); end
    n_cmp++; if (d_tot !== 10 || d_mis !== 10 || d_hit !== 0) begin n_fail++;
      $display("FAIL dm_thrash_counters: got h=%0d m=%0d t=%0d, need 0 10 10", d_hit, d_mis, d_tot); end
  endtask

  task automatic test_lru_order;
    logic [2:0] tags [0:10];
    logic       xm   [0:10];
    logic [7:0] fill_base [0:7];
    logic [7:0] base;
    logic [7:0] want;
    tags = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd5, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5};
    xm   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int t = 0; t < 8; t++) fill_base[t] = 8'h00;
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    for (int n = 0; n < 11; n++) begin
      // A new memory pattern per access tells stale cached bytes from fresh fills.
      base = 8'(8'h10 * n);
      ram_pattern(base);
      if (xm[n]) fill_base[tags[n]] = base;
      want = 8'(fill_base[tags[n]] + 8'd16);
      sb.push_back('{miss: xm[n], data: want});
      step(1'b1, 1'b0, {tags[n], 8'h50}, 8'h00, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data) begin n_fail++;
        $display("FAIL lru_order[%0d] tag %0d: got vld=%b miss=%b data=%h, need 1 %b %h", n, tags[n], l_vld, l_miss, l_dat, e.miss, e.data); end
    end
    n_cmp++; if (l_hit !== 3 || l_mis !== 8 || l_tot !== 11) begin n_fail++;
      $display("FAIL lru_order_counters: got h=%0d m=%0d t=%0d, need 3 8 11", l_hit, l_mis, l_tot); end
    ram_pattern(8'hE0);
  endtask

  task automatic test_random;
    logic [2:0] tg;
    int         seen_miss;
    seen_miss = 0;
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tg = 3'((i % 5) + 1);
      sb.push_back('{miss: 1'b1, data: 8'hF0});
      step(1'b1, 1'b0, {tg, 8'h50}, 8'h00, 1'b0);
      e = sb.pop_front();
      if (r_miss === 1'b1) seen_miss++;
      n_cmp++; if (r_vld !== 1'b1 || r_dat !== e.data || (i < 5 && r_miss !== e.miss)) begin n_fail++;
        $display("FAIL random[%0d]: got vld=%b miss=%b data=%h, need vld=1 data=%h miss=%b(first five only)", i, r_vld, r_miss, r_dat, e.data, e.miss); end
    end
    n_cmp++; if (r_tot !== 10 || (r_hit + r_mis) !== 10) begin n_fail++;
      $display("FAIL random_totals: got t=%0d h+m=%0d, need 10 10", r_tot, r_hit + r_mis); end
    n_cmp++; if (r_mis < 6 || r_mis !== seen_miss) begin n_fail++;
      $display("FAIL random_misses: got m=%0d observed=%0d, need >=6 and equal", r_mis, seen_miss); end
  endtask

  task automatic test_direct_mapped;
    logic [10:0] addr [0:3];
    logic        lm   [0:3];
    addr = '{11'h150, 11'h250, 11'h250, 11'h150};
    lm   = '{1'b1, 1'b1, 1'b0, 1'b0};
    step(1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
    sb.push_back('{miss: 1'b1, data: 8'hF0});
    sb.push_back('{miss: 1'b1, data: 8'hF0});
    sb.push_back('{miss: 1'b0, data: 8'hF0});
    sb.push_back('{miss: 1'b1, data: 8'hF0});
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, addr[i], 8'h00, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (d_vld !== 1'b1 || d_miss !== e.miss || d_dat !== e.data) begin n_fail++;
        $display("FAIL direct_mapped[%0d]: got vld=%b miss=%b data=%h, need 1 %b %h", i, d_vld, d_miss, d_dat, e.miss, e.data); end
      n_cmp++; if (l_miss !== lm[i]) begin n_fail++;
        $display("FAIL assoc_same_set[%0d]: got miss=%b, need %b", i, l_miss, lm[i]); end
    end
  endtask

  task automatic test_reset_midstream;
    step(1'b1, 1'b0, 11'h150, 8'h00, 1'b1);
    n_cmp++; if (l_vld !== 1'b0 || l_hit !== 0 || l_mis !== 0 || l_tot !== 0) begin n_fail++;
      $display("FAIL reset_midstream: got vld=%b h=%0d m=%0d t=%0d, need 0 0 0 0", l_vld, l_hit, l_mis, l_tot); end
    sb.push_back('{miss: 1'b1, data: 8'hF0});
    step(1'b1, 1'b0, 11'h150, 8'h00, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (l_vld !== 1'b1 || l_miss !== e.miss || l_dat !== e.data || l_tot !== 1) begin n_fail++;
      $display("FAIL post_reset_read: got vld=%b miss=%b data=%h t=%0d, need 1 %b %h 1", l_vld, l_miss, l_dat, l_tot, e.miss, e.data); end
  endtask

  initial begin
    ram_pattern(8'hE0);
    test_reset();
    test_cold_read();
    test_idle();
    test_write_alloc();
    test_back_to_back();
    test_lru_thrash();
    test_lru_order();
    test_random();
    test_direct_mapped();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cache.md
# multi_cache

Parameterised N-way set-associative L1 data cache model with hit/miss/access statistics. It sits between a byte-wide load/store requester and a 32-byte memory window (`iRAM32`) from which lines are filled in zero wait states. Replacement is selectable between true LRU and pseudo-random (LFSR). It is used to compare associativity and replacement policies by hit rate.

## Interface
- `WAY_COUNT`, default 4: associativity; legal values 1, 2, 4, 8.
- `USE_RANDOM_REPLACEMENT`, default 0: 1 selects the LFSR victim; 0 selects true LRU.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ivalid` input 1: an access request is present this cycle.
- `iRW` input 1: 0 = read, 1 = write.
- `iaddress` input 11: byte address; tag `[10:8]`, set index `[7:4]` (16 sets), byte offset `[3:0]` (16-byte lines).
- `iRAM32` input 32×8 (unpacked `[0:31]`): backing-memory window used for line fills.
- `iwrite_data` input 8: store data.
- `L1miss` output 1: the access just completed missed.
- `ovalid` output 1: a response is valid.
- `oread_data` output 8: load data, or echoed store data.
- `hit_count` output 32: cumulative hits.
- `miss_count` output 32: cumulative misses.
- `total_accesses` output 32: cumulative accesses.

## Operation
- Storage: 16 sets × `WAY_COUNT` ways. Each way holds a valid bit, a 3-bit tag and 16 data bytes.
- Lookup: the access hits if any valid way in set `iaddress[7:4]` has a tag equal to `iaddress[10:8]`. At most one way can match.
- Miss fill:
  - Victim choice: the lowest-numbered invalid way if one exists; otherwise the policy victim.
  - Line fill: byte k of the victim line is loaded from `iRAM32[{iaddress[4], k[3:0]}]` for k = 0..15.
  - The victim's tag is set and its valid bit is set to 1.
- Read: `oread_data` = the addressed byte. On a miss this is the filled byte `iRAM32[iaddress[4:0]]`.
- Write: write-allocate. On a miss, fill the line first, then overwrite the addressed byte with `iwrite_data`. `oread_data` = `iwrite_data`. There is no write-back port, so no dirty state is kept.
- LRU (`USE_RANDOM_REPLACEMENT`=0):
  - Each way has a per-set age of log2(`WAY_COUNT`) bits.
  - On every access, the touched way's age becomes 0, and every way in that set whose age was lower than the touched way's old age increments by 1.
  - The victim is the way with the maximum age.
- Random (`USE_RANDOM_REPLACEMENT`=1):
  - A 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 and reset seed 16'hACE1 advances every cycle that `rst` is low.
  - The victim is `lfsr[log2(WAY_COUNT)-1:0]`.
- `WAY_COUNT`=1: the cache is direct-mapped; the only victim is way 0.
- Counters (32-bit, wrap modulo 2^32):
  - `total_accesses` increments on every accepted access.
  - Exactly one of `hit_count` or `miss_count` increments per accepted access.
  - Invariant: `hit_count` + `miss_count` = `total_accesses`.

## Timing
- An access is accepted on every rising edge where `ivalid`=1 and `rst`=0. The interface is fully pipelined at one access per cycle with no stall and no ready signal.
- Latency is 1 cycle. `ovalid`, `L1miss` and `oread_data` are registered and valid in the cycle following acceptance. Counters, tags, data, LRU and valid state update on that same edge.
- Back-to-back accesses to the same set see all state updates from the previous access.
- Cycles with `ivalid`=0: `ovalid`=0 and `L1miss`=0 next cycle; `oread_data` holds its value; counters hold.
- Reset values: all valid bits 0, LRU ages = way index, LFSR = 16'hACE1, `ovalid`=0, `L1miss`=0, `oread_data`=0, all counters 0.
- If `rst`=1 in the same cycle as `ivalid`=1, reset wins: the access is dropped and not counted.
- `iRAM32` is sampled combinationally at the accepting edge.

## Test plan
- Cold read at 11'h150 after reset, with `iRAM32[i]`=8'hE0+i → next cycle `ovalid`=1, `L1miss`=1, `oread_data`=8'hF0; counters: miss 1, hit 0, total 1.
- Repeat read at 11'h150 → `L1miss`=0, `oread_data`=8'hF0; hit_count=1.
- 4-way LRU: reads to tags 1, 2, 3, 4, 5 at set 5 (addresses 11'h150, 11'h250, 11'h350, 11'h450, 11'h550), then 1, 2, 3, 4, 5 again → all 10 accesses miss; total=10, misses=10, hits=0.
- 4-way random, same 10-access sequence → first 5 accesses miss; total=10; hits+misses=10; misses ≥ 6; the re-access of tag 5 hits unless tag 5 was itself evicted.
- Write 8'h3C to 11'h153 (miss, allocate), then read 11'h153 → second access hits with `oread_data`=8'h3C; read 11'h154 → hits with 8'hF4.
- Assert `rst` mid-stream with `ivalid`=1 → all counters 0 and `ovalid`=0 next cycle; the next read of a previously cached address misses.
